// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and data access.
// Latches each granted request, runs the memory handshake, and aborts hung accesses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic [DATA_WIDTH-1:0] ifData,
    output logic                  ifDone,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWData,
    output logic [DATA_WIDTH-1:0] dRData,
    output logic                  dDone,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic [DATA_WIDTH-1:0] memRData,
    input  logic                  memReady,
    output logic                  busy,
    output logic                  timeoutErr
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0] state_r;
    logic [7:0] waitCnt_r;
    logic       lastGrantD_r;
    logic       grantI_s;
    logic       grantD_s;
    logic       waitExpired_s;

    // Round-robin arbitration; on a tie the side not served last wins.
    always_comb begin
        grantI_s = 1'b0;
        grantD_s = 1'b0;
        if (ifReq && dReq) begin
            grantI_s = lastGrantD_r;
            grantD_s = !lastGrantD_r;
        end else if (ifReq) begin
            grantI_s = 1'b1;
        end else if (dReq) begin
            grantD_s = 1'b1;
        end else begin
            grantI_s = 1'b0;
            grantD_s = 1'b0;
        end
    end

    // Watchdog limit reached in the current BUSY cycle.
    always_comb begin
        waitExpired_s = (waitCnt_r == WAIT_LAST);
    end

    assign busy = (state_r != IDLE);

    // Transaction sequencing: grant, memory handshake, watchdog abort, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            waitCnt_r    <= 8'd0;
            lastGrantD_r <= 1'b0;
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddr      <= {ADDR_WIDTH{1'b0}};
            memWData     <= {DATA_WIDTH{1'b0}};
            ifData       <= {DATA_WIDTH{1'b0}};
            dRData       <= {DATA_WIDTH{1'b0}};
            ifDone       <= 1'b0;
            dDone        <= 1'b0;
            timeoutErr   <= 1'b0;
        end else begin
            ifDone <= 1'b0;
            dDone  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grantI_s) begin
                        memReq       <= 1'b1;
                        memWe        <= 1'b0;
                        memAddr      <= ifAddr;
                        waitCnt_r    <= 8'd0;
                        lastGrantD_r <= 1'b0;
                        state_r      <= BUSY_I;
                    end else if (grantD_s) begin
                        memReq       <= 1'b1;
                        memWe        <= dWe;
                        memAddr      <= dAddr;
                        memWData     <= dWData;
                        waitCnt_r    <= 8'd0;
                        lastGrantD_r <= 1'b1;
                        state_r      <= BUSY_D;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (memReady) begin
                        // memWe still holds the latched direction, so a store leaves dRData alone.
                        if (state_r == BUSY_I) begin
                            ifData <= memRData;
                        end else if (!memWe) begin
                            dRData <= memRData;
                        end else begin
                            dRData <= dRData;
                        end
                        memReq  <= 1'b0;
                        memWe   <= 1'b0;
                        ifDone  <= (state_r == BUSY_I);
                        dDone   <= (state_r == BUSY_D);
                        state_r <= RESP;
                    end else if (waitExpired_s) begin
                        if (state_r == BUSY_I) begin
                            ifData <= {DATA_WIDTH{1'b1}};
                        end else begin
                            dRData <= {DATA_WIDTH{1'b1}};
                        end
                        timeoutErr <= 1'b1;
                        memReq     <= 1'b0;
                        memWe      <= 1'b0;
                        ifDone     <= (state_r == BUSY_I);
                        dDone      <= (state_r == BUSY_D);
                        state_r    <= RESP;
                    end else begin
                        waitCnt_r <= waitCnt_r + 8'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    memReq  <= 1'b0;
                    memWe   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifData;
    logic        ifDone;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic [31:0] dRData;
    logic        dDone;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memReady;
    logic        busy;
    logic        timeoutErr;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifDone(ifDone),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dRData(dRData), .dDone(dDone),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memReady(memReady), .busy(busy), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Transaction-level model state
    logic [31:0] mIf;
    logic [31:0] mDR;
    bit          mTo;
    bit          mLastD;

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] expData;
        bit          expTo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs one granted transaction; called at the negedge just before the granting edge.
    task automatic serve(input bit isD, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                         input logic [31:0] expData, input bit expTo, input string tag);
        int n;
        int k;
        int expCycles;
        expCycles = (delay < MW) ? delay + 1 : MW;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!memReq && n < 8);
        chk({tag, ".grantLat"}, n, 1);
        if (!memReq) return;
        k = 0;
        while (memReq && k < 64) begin
            chk({tag, ".memAddr"}, memAddr, addr);
            chk({tag, ".memWe"}, memWe, we);
            if (we) chk({tag, ".memWData"}, memWData, wdata);
            chk({tag, ".busyB"}, busy, 1);
            chk({tag, ".doneB"}, {ifDone, dDone}, 2'b00);
            memReady = (k == delay);
            memRData = (k == delay) ? rdata : $urandom;
            if (isD) begin
                dAddr  = $urandom;
                dWData = $urandom;
            end else begin
                ifAddr = $urandom;
            end
            @(negedge clk);
            k++;
        end
        memReady = 1'b0;
        chk({tag, ".busyCycles"}, k, expCycles);
        chk({tag, ".memReqR"}, memReq, 0);
        chk({tag, ".memWeR"}, memWe, 0);
        chk({tag, ".doneR"}, {ifDone, dDone}, isD ? 2'b01 : 2'b10);
        chk({tag, ".busyR"}, busy, 1);
        chk({tag, ".data"}, isD ? dRData : ifData, expData);
        chk({tag, ".timeoutErr"}, timeoutErr, expTo);
        if (isD) dReq = 1'b0;
        else ifReq = 1'b0;
        @(negedge clk);
        chk({tag, ".busyIdle"}, busy, 0);
        chk({tag, ".memReqIdle"}, memReq, 0);
        chk({tag, ".doneIdle"}, {ifDone, dDone}, 2'b00);
    endtask

    // Derives expectations from the model rules, then serves and updates the model.
    task automatic txn(input bit isD, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                       input string tag);
        logic [31:0] expData;
        if (delay >= MW) expData = 32'hFFFF_FFFF;
        else if (isD && we) expData = mDR;
        else expData = rdata;
        if (delay >= MW) mTo = 1'b1;
        serve(isD, isD && we, addr, wdata, delay, rdata, expData, mTo, tag);
        if (isD) mDR = expData;
        else mIf = expData;
        mLastD = isD;
    endtask

    task automatic doReset();
        reset = 1'b1;
        ifReq = 1'b0;
        dReq = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mIf = 32'h0;
        mDR = 32'h0;
        mTo = 1'b0;
        mLastD = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeLimit: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 0,  32'h2008_000A, 32'h2008_000A, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h1111_1111, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 1,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 3,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 9,  32'h2222_2222, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0104, 32'h55AA_55AA, 0, 32'h3333_3333, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0, 20, 32'h4444_4444, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_004C, 32'h0, 0,  32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1};

        reset = 1'b1;
        ifReq = 1'b0; ifAddr = 32'h0;
        dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWData = 32'h0;
        memRData = 32'h0; memReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.memReq", memReq, 0);
        chk("rst.memWe", memWe, 0);
        chk("rst.memAddr", memAddr, 32'h0);
        chk("rst.memWData", memWData, 32'h0);
        chk("rst.ifData", ifData, 32'h0);
        chk("rst.dRData", dRData, 32'h0);
        chk("rst.done", {ifDone, dDone}, 2'b00);
        chk("rst.busy", busy, 0);
        chk("rst.timeoutErr", timeoutErr, 0);
        reset = 1'b0;

        // Directed vector table, one requester at a time
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].isD) begin
                dAddr = vecs[i].addr; dWe = vecs[i].we; dWData = vecs[i].wdata; dReq = 1'b1;
            end else begin
                ifAddr = vecs[i].addr; ifReq = 1'b1;
            end
            serve(vecs[i].isD, vecs[i].isD && vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].delay, vecs[i].rdata, vecs[i].expData, vecs[i].expTo,
                  $sformatf("vec%0d", i));
        end

        // Reset mid-transaction with address churn; timeoutErr is set at this point
        ifAddr = 32'h40; ifReq = 1'b1;
        @(negedge clk);
        chk("midRst.memReq", memReq, 1);
        chk("midRst.memAddr0", memAddr, 32'h40);
        ifAddr = 32'h80;
        @(negedge clk);
        chk("churn.memAddr1", memAddr, 32'h40);
        @(negedge clk);
        chk("churn.memAddr2", memAddr, 32'h40);
        reset = 1'b1;
        @(negedge clk);
        chk("midRst.busy", busy, 0);
        chk("midRst.memReqOff", memReq, 0);
        chk("midRst.ifDone", ifDone, 0);
        chk("midRst.timeoutErr", timeoutErr, 0);
        reset = 1'b0;
        mIf = 32'h0; mDR = 32'h0; mTo = 1'b0; mLastD = 1'b0;
        txn(1'b0, 1'b0, 32'h80, 32'h0, 1, 32'h600D_CAFE, "afterRst");

        // memReady while idle must be ignored
        memReady = 1'b1; memRData = 32'h1357_9BDF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idleRdy.busy", busy, 0);
            chk("idleRdy.memReq", memReq, 0);
            chk("idleRdy.done", {ifDone, dDone}, 2'b00);
            chk("idleRdy.ifData", ifData, mIf);
            chk("idleRdy.dRData", dRData, mDR);
        end
        memReady = 1'b0;

        // Contention from reset: D, I, D, I with drop-and-re-raise
        doReset();
        ifAddr = 32'h1000; dAddr = 32'h2000; dWe = 1'b0; ifReq = 1'b1; dReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) txn(1'b1, 1'b0, 32'h2000, 32'h0, i, 32'hA000_0000 + i, $sformatf("rr%0d", i));
            else txn(1'b0, 1'b0, 32'h1000, 32'h0, i, 32'hB000_0000 + i, $sformatf("rr%0d", i));
            if (i % 2 == 0) begin
                dAddr = 32'h2000; dWe = 1'b0; dReq = 1'b1;
            end else begin
                ifAddr = 32'h1000; ifReq = 1'b1;
            end
        end
        ifReq = 1'b0; dReq = 1'b0;

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            int p;
            int di;
            int dd;
            logic [31:0] aI;
            logic [31:0] aD;
            logic [31:0] wd;
            logic [31:0] ri;
            logic [31:0] rd;
            bit we;
            p = $urandom_range(0, 2);
            aI = $urandom & 32'hFFFF_FFFC;
            aD = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            di = $urandom_range(0, 5);
            dd = $urandom_range(0, 5);
            ri = $urandom;
            rd = $urandom;
            ifAddr = aI; dAddr = aD; dWe = we; dWData = wd;
            ifReq = (p != 1);
            dReq = (p != 0);
            if (p == 0) begin
                txn(1'b0, 1'b0, aI, 32'h0, di, ri, "rndI");
            end else if (p == 1) begin
                txn(1'b1, we, aD, wd, dd, rd, "rndD");
            end else if (!mLastD) begin
                txn(1'b1, we, aD, wd, dd, rd, "rndTieD");
                txn(1'b0, 1'b0, aI, 32'h0, di, ri, "rndTieI2");
            end else begin
                txn(1'b0, 1'b0, aI, 32'h0, di, ri, "rndTieI");
                txn(1'b1, we, aD, wd, dd, rd, "rndTieD2");
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch requester and the data-access requester of the pipelined CPU. It latches each request and drives a variable-latency memory handshake. It returns read data and a one-cycle done pulse to the owning requester, and exports a busy flag used to stall the pipeline. A cycle-count watchdog aborts transactions that hang.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MAX_WAIT, 15, max cycles in a BUSY state before abort (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; reset is synchronous and active-high
ifReq  input  1  instruction read request, held until ifDone
ifAddr  input  ADDR_WIDTH  instruction address
ifData  output  DATA_WIDTH  registered instruction read data
ifDone  output  1  one-cycle completion pulse for instruction side
dReq  input  1  data request, held until dDone
dWe  input  1  1 = write, 0 = read
dAddr  input  ADDR_WIDTH  data address
dWData  input  DATA_WIDTH  store data
dRData  output  DATA_WIDTH  registered load data
dDone  output  1  one-cycle completion pulse for data side
memReq  output  1  memory request, registered
memWe  output  1  memory write enable, registered
memAddr  output  ADDR_WIDTH  memory address, registered
memWData  output  DATA_WIDTH  memory write data, registered
memRData  input  DATA_WIDTH  memory read data, valid when memReady=1
memReady  input  1  memory completes current access this cycle
busy  output  1  state != IDLE; pipeline stall source
timeoutErr  output  1  sticky watchdog error flag

Behaviour:
- Reset (sync): state=IDLE; memReq=0, memWe=0, memAddr=0, memWData=0; ifData=0, dRData=0; ifDone=0, dDone=0; timeoutErr=0; lastGrantD=0; wait counter=0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration:
  - only ifReq -> grant I
  - only dReq -> grant D
  - both asserted: grant I if lastGrantD=1, else grant D (round-robin; after reset the first tie goes to D).
- Grant I: latch ifAddr; memWe=0.
- Grant D: latch dAddr, dWe, dWData.
- On either grant: memReq=1 and counter=0 from the next cycle; lastGrantD updated to grant==D; go BUSY_I or BUSY_D.
- BUSY_x:
  - memReq/memWe/memAddr/memWData held stable.
  - Requester input changes are ignored.
  - Counter increments each cycle memReady=0.
- BUSY_x with memReady=1 at edge:
  - Capture memRData into ifData (BUSY_I) or into dRData (BUSY_D read only).
  - On a write, dRData is unchanged.
  - memReq, memWe -> 0; go RESP. Done for owner=1 next cycle.
- BUSY_x with counter==MAX_WAIT-1 and memReady=0 (abort):
  - timeoutErr=1 (sticky until reset).
  - Owner data register = all ones; memReq=0; go RESP.
- RESP: exactly one cycle.
  - Owner's done=1, the other done=0.
  - No new grant this cycle, so a still-held request is not reissued.
  - Next state IDLE.
- Latency, from request sampled in IDLE at edge N:
  - memReq high cycle N+1.
  - With memReady at edge N+k (k>=1), done is high cycle N+k+1.
  - Minimum 3 cycles between successive grants.
- memReady outside BUSY states is ignored.
- busy=1 in BUSY_I, BUSY_D, RESP; 0 in IDLE (derived from registered state).
- At most one of ifDone/dDone is high in any cycle.
- Reset asserted mid-transaction:
  - Returns to IDLE next edge, no done pulse issued.
  - memReq=0 from the following cycle; timeoutErr cleared.

Test Plan:
- Single read: reset, ifReq=1, ifAddr=0x00000040, memReady=1 first BUSY cycle, memRData=0x2008000A -> memReq 1 cycle, memAddr=0x40, ifDone one pulse, ifData=0x2008000A, memWe=0 throughout.
- Data write with latency: dReq=1, dWe=1, dAddr=0x100, dWData=0xDEADBEEF, memReady after 3 cycles -> memWe=1, memWData stable 3 cycles, dDone pulse, dRData remains 0.
- Contention: ifReq and dReq held high from reset -> grant order D, I, D, I. Each done is one pulse; the requester drops req after its done and re-raises it 1 cycle later. No double issue.
- Timeout with MAX_WAIT=4: dReq read, memReady held 0 -> memReq drops after 4 BUSY cycles, dDone pulse, dRData=0xFFFFFFFF, timeoutErr=1. timeoutErr stays 1 through a later successful access until reset.
- Reset mid-op: in BUSY_I, assert reset 1 cycle -> state IDLE, memReq=0, no ifDone, busy=0. The next ifReq completes normally.
- Input churn: change ifAddr 0x40 -> 0x80 while in BUSY_I -> memAddr stays 0x40 until RESP.
